// File: rtl/gpio_poll_sched.sv
// gpio_poll_sched: one GPIO host channel shared by bank change reports and adaptive-interval host polls.
// Define GPIO_POLL_SCHED_STATS_EN to add saturating poll_count_o / change_count_o counters.
module gpio_poll_sched #(
  parameter int N_BANKS      = 4,
  parameter int MIN_INTERVAL = 256,
  parameter int MAX_INTERVAL = 16384,
  parameter int TIMEOUT      = 4096,
  localparam int BW = (N_BANKS > 2) ? $clog2(N_BANKS) : 1,
  localparam int IW = $clog2(MAX_INTERVAL + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [N_BANKS-1:0] report_req_i,
  output logic [N_BANKS-1:0] report_gnt_o,
  output logic               poll_o,
  output logic [BW-1:0]      poll_bank_o,
  input  logic               poll_done_i,
  input  logic               poll_changed_i,
  output logic               busy_o,
  output logic [IW-1:0]      interval_o,
  output logic               timeout_err_o
`ifdef GPIO_POLL_SCHED_STATS_EN
  ,
  output logic [31:0]        poll_count_o,
  output logic [31:0]        change_count_o
`endif
);
  localparam int TW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, GRANT, POLL, WAIT} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d, interval_q, interval_d;
  logic [IW:0] dbl;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [N_BANKS-1:0] gnt_q, gnt_d;
  logic [BW-1:0] ptr_q, ptr_d, bank_q, bank_d, win, cand;
  logic poll_q, poll_d, busy_q, busy_d, err_q, err_d;
  logic any_req, poll_due, done, expired, leave;
  // Round-robin search starting at the pointer, wrapping at N_BANKS-1.
  always_comb begin
    win = '0;
    any_req = 1'b0;
    cand = ptr_q;
    for (int i = 0; i < N_BANKS; i++) begin
      if (!any_req && report_req_i[cand]) begin
        win = cand;
        any_req = 1'b1;
      end
      cand = (cand == BW'(N_BANKS - 1)) ? '0 : cand + 1'b1;
    end
  end
  always_comb begin
    poll_due = cnt_q == interval_q;
    done = state_q == WAIT && poll_done_i;
    expired = state_q == WAIT && !poll_done_i && tmr_q == TW'(TIMEOUT - 1);
    leave = done || expired;
    dbl = {interval_q, 1'b0};
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = poll_due ? POLL : (any_req ? GRANT : IDLE);
      GRANT:   state_d = IDLE;
      POLL:    state_d = WAIT;
      WAIT:    state_d = leave ? IDLE : WAIT;
      default: state_d = IDLE;
    endcase
    cnt_d = (state_d == POLL) ? '0 :
            ((state_q == IDLE || state_q == GRANT) && !poll_due) ? cnt_q + 1'b1 : cnt_q;
    tmr_d = (state_q == WAIT) ? tmr_q + 1'b1 : TW'(1);
    gnt_d = (state_q == IDLE && !poll_due && any_req) ? N_BANKS'(1) << win : '0;
    ptr_d = (|gnt_d) ? ((win == BW'(N_BANKS - 1)) ? '0 : win + 1'b1) : ptr_q;
    bank_d = leave ? ((bank_q == BW'(N_BANKS - 1)) ? '0 : bank_q + 1'b1) : bank_q;
    // A timeout backs off exactly like an unchanged result.
    interval_d = !leave ? interval_q :
                 (done && poll_changed_i) ? IW'(MIN_INTERVAL) :
                 (dbl > (IW+1)'(MAX_INTERVAL)) ? IW'(MAX_INTERVAL) : dbl[IW-1:0];
    poll_d = state_d == POLL;
    busy_d = state_d != IDLE;
    err_d = err_q | expired;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      tmr_q      <= '0;
      interval_q <= IW'(MIN_INTERVAL);
      gnt_q      <= '0;
      ptr_q      <= '0;
      bank_q     <= '0;
      poll_q     <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tmr_q      <= tmr_d;
      interval_q <= interval_d;
      gnt_q      <= gnt_d;
      ptr_q      <= ptr_d;
      bank_q     <= bank_d;
      poll_q     <= poll_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end
  assign report_gnt_o  = gnt_q;
  assign poll_o        = poll_q;
  assign poll_bank_o   = bank_q;
  assign busy_o        = busy_q;
  assign interval_o    = interval_q;
  assign timeout_err_o = err_q;
`ifdef GPIO_POLL_SCHED_STATS_EN
  logic [31:0] poll_cnt_q, poll_cnt_d, chg_cnt_q, chg_cnt_d;
  always_comb begin
    poll_cnt_d = (poll_d && poll_cnt_q != '1) ? poll_cnt_q + 1'b1 : poll_cnt_q;
    chg_cnt_d = (done && poll_changed_i && chg_cnt_q != '1) ? chg_cnt_q + 1'b1 : chg_cnt_q;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      poll_cnt_q <= '0;
      chg_cnt_q  <= '0;
    end else begin
      poll_cnt_q <= poll_cnt_d;
      chg_cnt_q  <= chg_cnt_d;
    end
  end
  assign poll_count_o   = poll_cnt_q;
  assign change_count_o = chg_cnt_q;
`endif
endmodule
